cassette_rec: RTL and testbench
===============================

Name: cassette_rec

Overview:
- Cassette recorder: the write-side counterpart of the tape player.
- Watches the CoCo cassette output (1-bit comparator of the cassette DAC) while the motor relay is on.
- Decodes CoCo FSK into bits: one 2400 Hz cycle = 1, one 1200 Hz cycle = 0.
- Locks byte alignment on the 0x55 leader and writes the raw CAS byte stream into SDRAM through a single-byte holding register, ready for later download or replay.

Parameters:
- ADDR_W, 25: SDRAM byte address width.
- BASE_ADDR, 25'h0100000: first SDRAM byte address of the recording.
- QTICK_MIN, 200: shorter periods (in Q ticks) are glitches.
- QTICK_SPLIT, 560: periods below this are bit 1, at or above are bit 0 (2400 Hz ≈ 373, 1200 Hz ≈ 746 ticks).
- QTICK_MAX, 1100: a period reaching this is a gap/silence.
- MAX_LEN, 24'hFFFFFF: byte capacity.

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- q_en  in  1  one-clk pulse per CoCo Q cycle (≈0.894886 MHz)
- motor  in  1  cassette relay (cas_relay)
- cas_in  in  1  cassette output comparator bit, asynchronous
- arm  in  1  record enable from OSD
- sdram_addr  out  ADDR_W  write address
- sdram_din  out  8  write data
- sdram_we  out  1  write request, held until ack
- sdram_ack  in  1  one-clk write-complete pulse
- rec_len  out  24  bytes committed to SDRAM
- rec_busy  out  1  high in HUNT or LOCKED
- overflow  out  1  sticky: byte dropped because a write was still pending
- full  out  1  sticky: byte dropped because rec_len == MAX_LEN

Behaviour:
- Reset values:
  - Outputs: sdram_we=0, sdram_addr=BASE_ADDR, sdram_din=0, rec_len=0, overflow=0, full=0, rec_busy=0.
  - Internal: state IDLE, shift register 0, bit count 0, period counter 0, have_ref=0.
- Input conditioning:
  - cas_in passes through a 2-flop synchroniser.
  - A rising edge is detected on the synchronised value; every synchronised edge is seen.
- Period counter:
  - Increments on q_en and saturates at QTICK_MAX.
  - Clears on every accepted rising edge, and whenever the state enters HUNT.
- States:
  - IDLE: arm=0. The arm 0→1 edge clears rec_len, overflow and full, sets sdram_addr=BASE_ADDR, and goes to WAIT_MOTOR.
  - WAIT_MOTOR: motor=1 goes to HUNT with have_ref=0.
  - HUNT: classify bits; shift LSB-first, shreg <= {bit, shreg[7:1]}. Once at least 8 bits have been shifted since entry and shreg==8'h55, emit 0x55, clear the bit count, and go to LOCKED.
  - LOCKED: after every 8th bit, emit shreg and clear the bit count.
  - From HUNT or LOCKED:
    - motor=0 → WAIT_MOTOR.
    - Counter reaching QTICK_MAX → HUNT, have_ref=0.
    - In both cases partial bits are discarded.
  - arm=0 from any state → IDLE. A pending write still completes; rec_len remains valid.
- Edge classification on a rising edge:
  - have_ref=0: set have_ref, no bit.
  - count < QTICK_MIN: edge ignored, counter not cleared.
  - QTICK_MIN ≤ count < QTICK_SPLIT: bit 1.
  - QTICK_SPLIT ≤ count < QTICK_MAX: bit 0.
- Emit and write handshake:
  - If no write is pending and rec_len < MAX_LEN: sdram_din <= byte, sdram_we <= 1 on the next clk.
  - sdram_addr and sdram_din stay stable while sdram_we=1.
  - On the sdram_ack cycle: sdram_we <= 0, sdram_addr += 1, rec_len += 1.
- Boundary rules:
  - Emit while a write is pending → byte dropped, overflow <= 1.
  - Emit in the same cycle as sdram_ack → accepted. The new write starts next cycle at the incremented address; no overflow.
  - Emit when rec_len == MAX_LEN → dropped, full <= 1.
  - sdram_ack while sdram_we=0 → ignored.
  - Multiple motor sessions under one arm append contiguously (header block then data block).
- rec_busy = state is HUNT or LOCKED.

Decomposition:
- Package cassette_pkg: state enum (IDLE, WAIT_MOTOR, HUNT, LOCKED), LEADER_BYTE=8'h55, default tick constants.
- Sub-module cas_period_decoder: synchroniser, edge detect, period counter, classification. Outputs bit_valid, bit_val and gap. The parent keeps the FSM, shifter and SDRAM handshake.

Test Plan:
- Arm, motor on, 16×0x55 at 373/746-tick periods, then 0x3C, ack 3 clk after each we → SDRAM holds 0x55 (16 times) then 0x3C from BASE_ADDR; rec_len=17.
- Preamble of bits 1,0,1 then 0x55 stream (misaligned) → first written byte 0x55 at BASE_ADDR; no garbage bytes before it.
- Glitch pulse at 50 ticks inside a 746-tick cycle → still decoded as single bit 0; byte values unchanged.
- Motor off after 3 bits of a byte, motor on, leader, 0xA5 → partial bits dropped; 0xA5 at next address; rec_len continuous.
- Hold sdram_ack low for 20000 clk while bytes arrive → overflow=1, only the first stalled byte written; ack in the same cycle as an emit → no overflow, addresses consecutive.
- MAX_LEN=4, send 6 bytes → rec_len=4, full=1. Assert reset_n low mid-write → all outputs at reset values immediately.

Source files
------------

// File: rtl/cassette_pkg.sv
// rtl/cassette_pkg.sv - shared types and constants for the cassette recorder
package cassette_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MOTOR,
    HUNT,
    LOCKED
  } rec_state_t;

  localparam logic [7:0] LEADER_BYTE = 8'h55;

  // Period thresholds in Q ticks (2400 Hz ~ 373, 1200 Hz ~ 746)
  localparam int DEF_QTICK_MIN   = 200;
  localparam int DEF_QTICK_SPLIT = 560;
  localparam int DEF_QTICK_MAX   = 1100;

endpackage

// File: rtl/cas_period_decoder.sv
// rtl/cas_period_decoder.sv - FSK period measurement and bit classification
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   q_en          one-clk pulse per Q cycle, the period time base
//   cas_in        asynchronous cassette comparator bit
//   clr           clear the period counter and drop the reference edge
//   bit_valid     one-clk strobe: a complete period was classified
//   bit_val       classified bit, valid with bit_valid (1 = short period)
//   gap           period counter is saturated (silence)
module cas_period_decoder #(
  parameter int QTICK_MIN   = 200,
  parameter int QTICK_SPLIT = 560,
  parameter int QTICK_MAX   = 1100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic q_en,
  input  logic cas_in,
  input  logic clr,
  output logic bit_valid,
  output logic bit_val,
  output logic gap
);

  localparam int CW = $clog2(QTICK_MAX + 1);
  localparam logic [CW-1:0] MIN_C   = CW'(QTICK_MIN);
  localparam logic [CW-1:0] SPLIT_C = CW'(QTICK_SPLIT);
  localparam logic [CW-1:0] MAX_C   = CW'(QTICK_MAX);

  // sync[1:0] is the synchroniser, sync[2] the previous synchronised value
  logic [2:0]    sync;
  logic [CW-1:0] count;
  logic          have_ref;
  logic          rise;
  logic          too_short;
  logic          accept;

  assign rise      = sync[1] & ~sync[2];
  assign gap       = (count == MAX_C);
  assign too_short = (count < MIN_C);
  // A glitch edge is dropped without restarting the period, so the real
  // cycle is still measured from its own rising edge.
  assign accept    = rise & ~(have_ref & too_short);
  assign bit_valid = rise & have_ref & ~too_short & ~gap;
  assign bit_val   = (count < SPLIT_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      count    <= '0;
      have_ref <= 1'b0;
    end else begin
      sync <= {sync[1:0], cas_in};
      if (clr) begin
        count    <= '0;
        have_ref <= 1'b0;
      end else if (accept) begin
        count    <= '0;
        have_ref <= 1'b1;
      end else if (q_en && !gap) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cassette_rec.sv
// rtl/cassette_rec.sv - CoCo cassette recorder: FSK decode, leader lock, SDRAM byte writer
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   q_en           one-clk pulse per CoCo Q cycle
//   motor          cassette relay
//   cas_in         cassette comparator bit (asynchronous)
//   arm            record enable; rising edge starts a new recording
//   sdram_addr/din write address and data, stable while sdram_we is high
//   sdram_we       write request, held until sdram_ack
//   sdram_ack      one-clk write-complete pulse
//   rec_len        bytes committed to SDRAM
//   rec_busy       decoder is hunting or locked
//   overflow       sticky: byte dropped while a write was pending
//   full           sticky: byte dropped at capacity
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int                ADDR_W      = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 25'h0100000,
  parameter int                QTICK_MIN   = DEF_QTICK_MIN,
  parameter int                QTICK_SPLIT = DEF_QTICK_SPLIT,
  parameter int                QTICK_MAX   = DEF_QTICK_MAX,
  parameter logic [23:0]       MAX_LEN     = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              q_en,
  input  logic              motor,
  input  logic              cas_in,
  input  logic              arm,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_we,
  input  logic              sdram_ack,
  output logic [23:0]       rec_len,
  output logic              rec_busy,
  output logic              overflow,
  output logic              full
);

  rec_state_t  state, state_nxt;
  logic        arm_d;
  logic        arm_rise;
  logic [7:0]  shreg, shreg_nxt, shifted;
  logic [3:0]  bcnt, bcnt_nxt;
  logic        emit;
  logic        hunt_clr;
  logic        bit_valid, bit_val, gap;
  logic        ack_ok;
  logic [23:0] len_now;

  cas_period_decoder #(
    .QTICK_MIN  (QTICK_MIN),
    .QTICK_SPLIT(QTICK_SPLIT),
    .QTICK_MAX  (QTICK_MAX)
  ) u_dec (
    .clk      (clk),
    .reset_n  (reset_n),
    .q_en     (q_en),
    .cas_in   (cas_in),
    .clr      (hunt_clr),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .gap      (gap)
  );

  assign arm_rise = arm & ~arm_d;
  assign shifted  = {bit_val, shreg[7:1]};
  assign rec_busy = (state == HUNT) || (state == LOCKED);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    emit      = 1'b0;
    hunt_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (arm_rise) state_nxt = WAIT_MOTOR;
      end
      WAIT_MOTOR: begin
        if (motor) begin
          state_nxt = HUNT;
          hunt_clr  = 1'b1;
          shreg_nxt = '0;
          bcnt_nxt  = '0;
        end
      end
      HUNT, LOCKED: begin
        if (!motor) begin
          state_nxt = WAIT_MOTOR;
          shreg_nxt = '0;
          bcnt_nxt  = '0;
        end else if (gap) begin
          state_nxt = HUNT;
          hunt_clr  = 1'b1;
          shreg_nxt = '0;
          bcnt_nxt  = '0;
        end else if (bit_valid) begin
          shreg_nxt = shifted;
          if (state == HUNT) begin
            // bcnt saturates at 8: it only has to prove a full byte was seen
            if (bcnt != 4'd8) bcnt_nxt = bcnt + 4'd1;
            if (bcnt >= 4'd7 && shifted == LEADER_BYTE) begin
              emit      = 1'b1;
              bcnt_nxt  = '0;
              state_nxt = LOCKED;
            end
          end else begin
            bcnt_nxt = bcnt + 4'd1;
            if (bcnt == 4'd7) begin
              emit     = 1'b1;
              bcnt_nxt = '0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!arm) begin
      state_nxt = IDLE;
      emit      = 1'b0;
      hunt_clr  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      arm_d <= 1'b0;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      arm_d <= arm;
      shreg <= shreg_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // A write completing in the emit cycle frees the holding register, so the
  // capacity test uses the length as it will be after that completion.
  assign ack_ok  = sdram_we & sdram_ack;
  assign len_now = ack_ok ? rec_len + 24'd1 : rec_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdram_we   <= 1'b0;
      sdram_addr <= BASE_ADDR;
      sdram_din  <= '0;
      rec_len    <= '0;
      overflow   <= 1'b0;
      full       <= 1'b0;
    end else begin
      if (ack_ok) begin
        sdram_we   <= 1'b0;
        sdram_addr <= sdram_addr + ADDR_W'(1);
        rec_len    <= rec_len + 24'd1;
      end
      if (arm_rise && state == IDLE) begin
        sdram_addr <= BASE_ADDR;
        rec_len    <= '0;
        overflow   <= 1'b0;
        full       <= 1'b0;
      end
      if (emit) begin
        if (sdram_we && !ack_ok) begin
          overflow <= 1'b1;
        end else if (len_now >= MAX_LEN) begin
          full <= 1'b1;
        end else begin
          sdram_din <= shifted;
          sdram_we  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cassette_rec.sv
// tb/tb_cassette_rec.sv - directed self-checking bench for cassette_rec
module tb_cassette_rec;

  localparam logic [24:0] BASE  = 25'h0100000;
  localparam int          T_MIN = 20;
  localparam int          T_SPL = 56;
  localparam int          T_MAX = 110;
  // q_en pulses every other clk, so a period of P ticks is 2*P clocks
  localparam int          P1    = 37;
  localparam int          P0    = 75;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        q_en = 1'b0;
  logic        motor = 1'b0;
  logic        cas_in = 1'b0;
  logic        arm = 1'b0;
  logic [24:0] addr_a, addr_b;
  logic [7:0]  din_a, din_b;
  logic        we_a, we_b;
  logic        ack_a = 1'b0;
  logic        ack_b = 1'b0;
  logic [23:0] len_a, len_b;
  logic        busy_a, busy_b, ovf_a, ovf_b, full_a, full_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_mode = 0;      // 0 auto ack after 3 clk, 1 hold off, 2 ack at fire_cyc
  int fire_cyc = -1;
  int wcnt_a = 0;
  int wcnt_b = 0;
  logic [7:0]  log_d[$];
  logic [24:0] log_a[$];
  logic [7:0]  log_bd[$];
  logic [7:0]  exp_d[$];

  cassette_rec #(
    .QTICK_MIN(T_MIN), .QTICK_SPLIT(T_SPL), .QTICK_MAX(T_MAX)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .q_en(q_en), .motor(motor), .cas_in(cas_in),
    .arm(arm), .sdram_addr(addr_a), .sdram_din(din_a), .sdram_we(we_a),
    .sdram_ack(ack_a), .rec_len(len_a), .rec_busy(busy_a), .overflow(ovf_a),
    .full(full_a)
  );

  cassette_rec #(
    .QTICK_MIN(T_MIN), .QTICK_SPLIT(T_SPL), .QTICK_MAX(T_MAX), .MAX_LEN(24'd4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .q_en(q_en), .motor(motor), .cas_in(cas_in),
    .arm(arm), .sdram_addr(addr_b), .sdram_din(din_b), .sdram_we(we_b),
    .sdram_ack(ack_b), .rec_len(len_b), .rec_busy(busy_b), .overflow(ovf_b),
    .full(full_b)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) q_en = ~q_en;

  always @(negedge clk) begin
    ack_a = 1'b0;
    if (ack_mode == 0 && we_a) begin
      wcnt_a++;
      if (wcnt_a >= 3) begin
        ack_a  = 1'b1;
        wcnt_a = 0;
      end
    end else begin
      wcnt_a = 0;
    end
    if (ack_mode == 2 && cyc == fire_cyc && we_a) ack_a = 1'b1;
    if (ack_a) begin
      log_a.push_back(addr_a);
      log_d.push_back(din_a);
    end
  end

  always @(negedge clk) begin
    ack_b = 1'b0;
    if (we_b) begin
      wcnt_b++;
      if (wcnt_b >= 3) begin
        ack_b  = 1'b1;
        wcnt_b = 0;
        log_bd.push_back(din_b);
      end
    end else begin
      wcnt_b = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, " count"}, 32'(log_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < log_d.size()) begin
        check($sformatf("%s data[%0d]", tag, i), 32'(log_d[i]), 32'(exp_d[i]));
        check($sformatf("%s addr[%0d]", tag, i), 32'(log_a[i]), 32'(BASE) + 32'(i));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    int p;
    p = b ? P1 : P0;
    cas_in = 1'b1;
    if (glitch) begin
      tick(6);
      cas_in = 1'b0;
      tick(3);
      cas_in = 1'b1;
      tick(p - 9);
    end else begin
      tick(p);
    end
    cas_in = 1'b0;
    tick(p);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic glitch);
    for (int i = 0; i < 8; i++) send_bit(v[i], glitch);
  endtask

  task automatic send_edge();
    cas_in = 1'b1;
    tick(4);
    cas_in = 1'b0;
    tick(4);
  endtask

  task automatic rearm();
    arm = 1'b0;
    tick(3);
    log_d.delete();
    log_a.delete();
    exp_d.delete();
    arm = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("reset we", 32'(we_a), 32'd0);
    check("reset addr", 32'(addr_a), 32'(BASE));
    check("reset din", 32'(din_a), 32'd0);
    check("reset len", 32'(len_a), 32'd0);
    check("reset ovf", 32'(ovf_a), 32'd0);
    check("reset full", 32'(full_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // leader of 16 x 0x55 then 0x3C
    arm = 1'b1;
    tick(3);
    check("wait motor busy", 32'(busy_a), 32'd0);
    motor = 1'b1;
    tick(3);
    check("hunt busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'h55, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_edge();
    tick(300);
    for (int i = 0; i < 16; i++) exp_d.push_back(8'h55);
    exp_d.push_back(8'h3C);
    check_log("leader");
    check("leader len", 32'(len_a), 32'd17);
    check("leader ovf", 32'(ovf_a), 32'd0);
    check("leader full", 32'(full_a), 32'd0);
    check("gap busy", 32'(busy_a), 32'd1);
    check("cap len", 32'(len_b), 32'd4);
    check("cap full", 32'(full_b), 32'd1);
    check("cap writes", 32'(log_bd.size()), 32'd4);
    for (int i = 0; i < log_bd.size(); i++)
      check($sformatf("cap data[%0d]", i), 32'(log_bd[i]), 32'h55);

    // misaligned preamble 1,0,1 ahead of the leader
    rearm();
    check("rearm len", 32'(len_a), 32'd0);
    check("rearm full", 32'(full_b), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h21, 1'b0);
    send_edge();
    tick(300);
    exp_d = '{8'h55, 8'h55, 8'h21};
    check_log("align");
    check("align len", 32'(len_a), 32'd3);

    // glitches inside every cycle of 0x3C, then a partial byte and motor off
    rearm();
    send_byte(8'h55, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_edge();
    tick(20);
    exp_d = '{8'h55, 8'h3C};
    check_log("glitch");
    motor = 1'b0;
    tick(5);
    check("motor off busy", 32'(busy_a), 32'd0);
    motor = 1'b1;
    tick(5);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_edge();
    tick(300);
    exp_d = '{8'h55, 8'h3C, 8'h55, 8'h55, 8'hA5};
    check_log("session");
    check("session len", 32'(len_a), 32'd5);

    // write stalled while further bytes arrive
    rearm();
    ack_mode = 1;
    send_byte(8'h55, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_edge();
    tick(20);
    check("stall ovf", 32'(ovf_a), 32'd1);
    check("stall we", 32'(we_a), 32'd1);
    check("stall addr", 32'(addr_a), 32'(BASE));
    check("stall din", 32'(din_a), 32'h55);
    check("stall len", 32'(len_a), 32'd0);
    ack_mode = 0;
    tick(20);
    exp_d = '{8'h55};
    check_log("stall");
    check("stall len after", 32'(len_a), 32'd1);
    check("stall ovf sticky", 32'(ovf_a), 32'd1);

    // ack lands in the same cycle as the next emit
    rearm();
    check("rearm ovf", 32'(ovf_a), 32'd0);
    ack_mode = 2;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    cas_in = 1'b1;
    fire_cyc = cyc + 2;
    tick(4);
    cas_in = 1'b0;
    tick(2);
    ack_mode = 0;
    tick(20);
    exp_d = '{8'h55, 8'h66};
    check_log("same cycle");
    check("same cycle ovf", 32'(ovf_a), 32'd0);
    check("same cycle len", 32'(len_a), 32'd2);

    // reset while a write is pending
    rearm();
    ack_mode = 1;
    send_byte(8'h55, 1'b0);
    send_edge();
    tick(5);
    check("pre reset we", 32'(we_a), 32'd1);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid reset we", 32'(we_a), 32'd0);
    check("mid reset addr", 32'(addr_a), 32'(BASE));
    check("mid reset din", 32'(din_a), 32'd0);
    check("mid reset len", 32'(len_a), 32'd0);
    check("mid reset ovf", 32'(ovf_a), 32'd0);
    check("mid reset full", 32'(full_a), 32'd0);
    check("mid reset busy", 32'(busy_a), 32'd0);
    tick(2);
    reset_n = 1'b1;
    ack_mode = 0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
